// File: rtl/gfx_pkg.sv
// gfx_pkg: types and constants shared by the line command sequencer and its
// edge mux. COORD_W and COLOR_W must match the line engine's bus widths.
package gfx_pkg;

  localparam int COORD_W = 8;
  localparam int COLOR_W = 24;
  localparam int CNT_W   = 16;

  localparam logic MODE_LINE = 1'b0;
  localparam logic MODE_TRI  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ISSUE  = 2'd1,
    ST_WAIT   = 2'd2,
    ST_FINISH = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } vtx_t;

  // Index of the final edge of a shape.
  function automatic logic [1:0] last_edge(input logic mode);
    return (mode == MODE_TRI) ? 2'd2 : 2'd0;
  endfunction

endpackage

// File: rtl/line_cmd_sequencer_edge_select.sv
// edge_select: combinational mux from an edge index to the endpoint pair
// of that edge of the shape. Edge 0 is v0->v1, edge 1 is v1->v2 and edge 2
// is v2->v0. Index 3 never occurs and falls back to edge 0.
//   edge_idx_i      edge being selected
//   v0_i,v1_i,v2_i  shape vertices
//   a_o, b_o        start / end point of the selected edge
module edge_select
  import gfx_pkg::*;
(
  input  logic [1:0] edge_idx_i,
  input  vtx_t       v0_i,
  input  vtx_t       v1_i,
  input  vtx_t       v2_i,
  output vtx_t       a_o,
  output vtx_t       b_o
);

  always_comb begin
    a_o = v0_i;
    b_o = v1_i;
    case (edge_idx_i)
      2'd1: begin
        a_o = v1_i;
        b_o = v2_i;
      end
      2'd2: begin
        a_o = v2_i;
        b_o = v0_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/line_cmd_sequencer.sv
// line_cmd_sequencer: accepts line / triangle-outline commands over
// valid/ready and issues one line-engine job per edge using start/done.
// Endpoints and colour stay stable for the whole job because the engine
// reads them combinationally during its setup.
//   clk, reset (async, active-high; the engine shares this reset)
//   cmd_valid/cmd_ready, cmd_mode, cmd_x0..cmd_y2, cmd_color  command in
//   eng_start, eng_x0..eng_y1, eng_color, eng_done             engine side
//   eng_pixel_valid                                            pixel strobe
//   busy, cmd_done, edge_idx                                   status
// Optional feature macro PIXEL_COUNT_EN adds pix_count, the number of pixel
// strobes seen during the current command (saturating).
//
// state  | meaning
// IDLE   | ready for a command
// ISSUE  | eng_start high for one cycle with the current edge endpoints
// WAIT   | engine busy on the current edge, waiting for eng_done
// FINISH | cmd_done high for one cycle, then back to IDLE
module line_cmd_sequencer #(
  parameter int COORD_W = gfx_pkg::COORD_W,
  parameter int COLOR_W = gfx_pkg::COLOR_W,
  parameter int CNT_W   = gfx_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_mode,
  input  logic [COORD_W-1:0] cmd_x0,
  input  logic [COORD_W-1:0] cmd_y0,
  input  logic [COORD_W-1:0] cmd_x1,
  input  logic [COORD_W-1:0] cmd_y1,
  input  logic [COORD_W-1:0] cmd_x2,
  input  logic [COORD_W-1:0] cmd_y2,
  input  logic [COLOR_W-1:0] cmd_color,
  output logic               eng_start,
  output logic [COORD_W-1:0] eng_x0,
  output logic [COORD_W-1:0] eng_y0,
  output logic [COORD_W-1:0] eng_x1,
  output logic [COORD_W-1:0] eng_y1,
  output logic [COLOR_W-1:0] eng_color,
  input  logic               eng_done,
  input  logic               eng_pixel_valid,
  output logic               busy,
  output logic               cmd_done,
  output logic [1:0]         edge_idx
`ifdef PIXEL_COUNT_EN
  ,
  output logic [CNT_W-1:0]   pix_count
`endif
);
  import gfx_pkg::*;

  seq_state_e         state_q, state_d;
  vtx_t               v0_q, v1_q, v2_q, v0_d, v1_d, v2_d;
  logic               mode_q, mode_d;
  logic [COLOR_W-1:0] color_q, color_d;
  logic [1:0]         edge_q, edge_d;
  vtx_t               sel_a, sel_b;
  logic               accept;

  logic               ready_q, busy_q, start_q, done_q;
  vtx_t               ep_a_q, ep_b_q;

  assign accept = cmd_valid && (state_q == ST_IDLE);

  always_comb begin
    state_d = state_q;
    v0_d    = v0_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    mode_d  = mode_q;
    color_d = color_q;
    edge_d  = edge_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          v0_d    = '{x: cmd_x0, y: cmd_y0};
          v1_d    = '{x: cmd_x1, y: cmd_y1};
          v2_d    = '{x: cmd_x2, y: cmd_y2};
          mode_d  = cmd_mode;
          color_d = cmd_color;
          edge_d  = 2'd0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (eng_done) begin
          if (edge_q == last_edge(mode_q)) begin
            state_d = ST_FINISH;
          end else begin
            edge_d  = edge_q + 2'd1;
            state_d = ST_ISSUE;
          end
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // The mux looks at next-state index and vertices so the registered
  // endpoints are already correct in the ISSUE cycle, including edge 0
  // straight after accept.
  edge_select u_edge_select (
    .edge_idx_i (edge_d),
    .v0_i       (v0_d),
    .v1_i       (v1_d),
    .v2_i       (v2_d),
    .a_o        (sel_a),
    .b_o        (sel_b)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      v0_q    <= '0;
      v1_q    <= '0;
      v2_q    <= '0;
      mode_q  <= MODE_LINE;
      color_q <= '0;
      edge_q  <= 2'd0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      start_q <= 1'b0;
      done_q  <= 1'b0;
      ep_a_q  <= '0;
      ep_b_q  <= '0;
    end else begin
      state_q <= state_d;
      v0_q    <= v0_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      edge_q  <= edge_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      start_q <= (state_d == ST_ISSUE);
      done_q  <= (state_d == ST_FINISH);
      ep_a_q  <= sel_a;
      ep_b_q  <= sel_b;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = busy_q;
  assign eng_start = start_q;
  assign cmd_done  = done_q;
  assign edge_idx  = edge_q;
  assign eng_x0    = ep_a_q.x;
  assign eng_y0    = ep_a_q.y;
  assign eng_x1    = ep_b_q.x;
  assign eng_y1    = ep_b_q.y;
  assign eng_color = color_q;

`ifdef PIXEL_COUNT_EN
  logic [CNT_W-1:0] pix_q, pix_d;

  always_comb begin
    pix_d = pix_q;
    if (accept) begin
      pix_d = '0;
    end else if (busy_q && eng_pixel_valid && (pix_q != '1)) begin
      pix_d = pix_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pix_q <= '0;
    else       pix_q <= pix_d;
  end

  assign pix_count = pix_q;
`else
  localparam int unused_cnt_w = CNT_W;
  logic unused_pix_valid;
  assign unused_pix_valid = eng_pixel_valid;
`endif

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Testbench for line_cmd_sequencer. The bench plays the line engine: it
// answers each eng_start with max(|dx|,|dy|)+1 pixel strobes and a done
// pulse after a random latency, and checks every job against the edge list
// derived from the command's vertices.
module tb_line_cmd_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_mode;
  logic [7:0]  cmd_x0, cmd_y0, cmd_x1, cmd_y1, cmd_x2, cmd_y2;
  logic [23:0] cmd_color;
  logic        eng_start;
  logic [7:0]  eng_x0, eng_y0, eng_x1, eng_y1;
  logic [23:0] eng_color;
  logic        eng_done, eng_pixel_valid;
  logic        busy, cmd_done;
  logic [1:0]  edge_idx;
`ifdef PIXEL_COUNT_EN
  logic [15:0] pix_count;
`endif

  line_cmd_sequencer dut (
    .clk             (clk),
    .reset           (reset),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_mode        (cmd_mode),
    .cmd_x0          (cmd_x0),
    .cmd_y0          (cmd_y0),
    .cmd_x1          (cmd_x1),
    .cmd_y1          (cmd_y1),
    .cmd_x2          (cmd_x2),
    .cmd_y2          (cmd_y2),
    .cmd_color       (cmd_color),
    .eng_start       (eng_start),
    .eng_x0          (eng_x0),
    .eng_y0          (eng_y0),
    .eng_x1          (eng_x1),
    .eng_y1          (eng_y1),
    .eng_color       (eng_color),
    .eng_done        (eng_done),
    .eng_pixel_valid (eng_pixel_valid),
    .busy            (busy),
    .cmd_done        (cmd_done),
    .edge_idx        (edge_idx)
`ifdef PIXEL_COUNT_EN
    ,
    .pix_count       (pix_count)
`endif
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cx[3];
  int cy[3];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic set_vertices(input int x0, input int y0, input int x1, input int y1,
                              input int x2, input int y2);
    cx[0] = x0; cy[0] = y0;
    cx[1] = x1; cy[1] = y1;
    cx[2] = x2; cy[2] = y2;
  endtask

  task automatic scramble_fields();
    cmd_mode  = 1'($urandom);
    cmd_x0    = 8'($urandom); cmd_y0 = 8'($urandom);
    cmd_x1    = 8'($urandom); cmd_y1 = 8'($urandom);
    cmd_x2    = 8'($urandom); cmd_y2 = 8'($urandom);
    cmd_color = 24'($urandom);
  endtask

  // One complete command. hold keeps cmd_valid high with changing fields
  // while busy; abort_at >= 0 resets the DUT during that edge's WAIT.
  task automatic run_cmd(input string nm, input bit mode, input logic [23:0] col,
                         input bit hold, input int abort_at);
    int ne, a, b, npix, lat, exp_pix;
    logic [31:0] exp_ep;
    ne      = mode ? 3 : 1;
    exp_pix = 0;
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_x0 = 8'(cx[0]); cmd_y0 = 8'(cy[0]);
    cmd_x1 = 8'(cx[1]); cmd_y1 = 8'(cy[1]);
    cmd_x2 = 8'(cx[2]); cmd_y2 = 8'(cy[2]);
    cmd_color = col;
    chk({nm, ".ready_before"}, 64'(cmd_ready), 64'd1);
    step();
    if (hold) scramble_fields();
    else cmd_valid = 1'b0;
    for (int e = 0; e < ne; e++) begin
      a = e;
      b = (e + 1) % 3;
      exp_ep = {8'(cx[a]), 8'(cy[a]), 8'(cx[b]), 8'(cy[b])};
      chk({nm, ".start"}, 64'(eng_start), 64'd1);
      chk({nm, ".edge_idx"}, 64'(edge_idx), 64'(e));
      chk({nm, ".endpoints"}, 64'({eng_x0, eng_y0, eng_x1, eng_y1}), 64'(exp_ep));
      chk({nm, ".color"}, 64'(eng_color), 64'(col));
      chk({nm, ".busy"}, 64'(busy), 64'd1);
      chk({nm, ".ready_busy"}, 64'(cmd_ready), 64'd0);
      npix = imax(iabs(cx[b] - cx[a]), iabs(cy[b] - cy[a])) + 1;
      lat  = npix + 1 + int'($urandom_range(0, 3));
      for (int k = 0; k < lat; k++) begin
        eng_pixel_valid = (k >= 1) && (k <= npix);
        step();
        if (e == abort_at && k == 0) begin
          reset = 1'b1;
          #1;
          chk({nm, ".abort_ready"}, 64'(cmd_ready), 64'd1);
          chk({nm, ".abort_busy"}, 64'(busy), 64'd0);
          chk({nm, ".abort_start"}, 64'(eng_start), 64'd0);
          chk({nm, ".abort_done"}, 64'(cmd_done), 64'd0);
          chk({nm, ".abort_edge"}, 64'(edge_idx), 64'd0);
          eng_pixel_valid = 1'b0;
          cmd_valid = 1'b0;
          step();
          reset = 1'b0;
          for (int j = 0; j < 4; j++) begin
            step();
            chk({nm, ".post_abort_start"}, 64'(eng_start), 64'd0);
            chk({nm, ".post_abort_done"}, 64'(cmd_done), 64'd0);
          end
          return;
        end
        chk({nm, ".wait_start"}, 64'(eng_start), 64'd0);
        chk({nm, ".wait_ep"}, 64'({eng_x0, eng_y0, eng_x1, eng_y1}), 64'(exp_ep));
        chk({nm, ".wait_ready"}, 64'(cmd_ready), 64'd0);
        chk({nm, ".wait_done"}, 64'(cmd_done), 64'd0);
      end
      eng_pixel_valid = 1'b0;
      exp_pix += npix;
      eng_done = 1'b1;
      step();
      eng_done = 1'b0;
    end
    chk({nm, ".cmd_done"}, 64'(cmd_done), 64'd1);
    chk({nm, ".fin_start"}, 64'(eng_start), 64'd0);
`ifdef PIXEL_COUNT_EN
    chk({nm, ".pix_count"}, 64'(pix_count), 64'(exp_pix));
`endif
    step();
    chk({nm, ".done_pulse"}, 64'(cmd_done), 64'd0);
    chk({nm, ".idle_busy"}, 64'(busy), 64'd0);
    chk({nm, ".idle_ready"}, 64'(cmd_ready), 64'd1);
    chk({nm, ".idle_start"}, 64'(eng_start), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0;
    cmd_mode = 1'b0;
    cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = '0; cmd_y1 = '0; cmd_x2 = '0; cmd_y2 = '0;
    cmd_color = '0;
    eng_done = 1'b0;
    eng_pixel_valid = 1'b0;
    step();
    step();
    chk("rst.ready", 64'(cmd_ready), 64'd1);
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.start", 64'(eng_start), 64'd0);
    chk("rst.done", 64'(cmd_done), 64'd0);
    chk("rst.edge_idx", 64'(edge_idx), 64'd0);
    chk("rst.endpoints", 64'({eng_x0, eng_y0, eng_x1, eng_y1}), 64'd0);
    chk("rst.color", 64'(eng_color), 64'd0);
    reset = 1'b0;
    step();

    // Spurious done while idle.
    eng_done = 1'b1;
    step();
    eng_done = 1'b0;
    chk("spur.ready", 64'(cmd_ready), 64'd1);
    chk("spur.busy", 64'(busy), 64'd0);
    chk("spur.done", 64'(cmd_done), 64'd0);
    chk("spur.start", 64'(eng_start), 64'd0);
    step();
    chk("spur.done2", 64'(cmd_done), 64'd0);

    set_vertices(10, 20, 30, 20, 0, 0);
    run_cmd("line", 1'b0, 24'hFF0000, 1'b0, -1);

    set_vertices(0, 0, 3, 0, 0, 3);
    run_cmd("tri", 1'b1, 24'h00FF00, 1'b0, -1);

    set_vertices(7, 1, 2, 9, 12, 4);
    run_cmd("tri_hold", 1'b1, 24'h123456, 1'b1, -1);
    set_vertices(4, 4, 0, 11, 9, 9);
    run_cmd("after_hold", 1'b0, 24'h0000FF, 1'b0, -1);

    set_vertices(5, 5, 5, 5, 5, 5);
    run_cmd("degen", 1'b1, 24'hABCDEF, 1'b0, -1);

    set_vertices(1, 2, 8, 3, 6, 14);
    run_cmd("abort", 1'b1, 24'h777777, 1'b0, 1);
    set_vertices(3, 3, 13, 7, 0, 0);
    run_cmd("after_abort", 1'b1, 24'h010203, 1'b0, -1);

    for (int i = 0; i < 20; i++) begin
      set_vertices(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
      run_cmd("rand", 1'($urandom), 24'($urandom), ($urandom_range(0, 3) == 0), -1);
    end
    cmd_valid = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
